// File: rtl/ddram_arb_pkg.sv
// Shared types and helpers for the DDRAM round-robin arbiter.
package ddram_arb_pkg;

  localparam int AW    = 29;  // 64-bit word address width
  localparam int DW    = 64;  // data width
  localparam int CNT_W = 8;   // burst count width
  localparam int BE_W  = 8;   // byte-enable width

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RDCMD,
    RDDATA,
    DRAIN
  } arb_state_t;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [CNT_W-1:0] burst;
    logic [DW-1:0]    din;
    logic [BE_W-1:0]  be;
    logic             is_wr;
  } slot_t;

  // A zero-length read is issued as a single beat.
  function automatic logic [CNT_W-1:0] norm_burst(input logic [CNT_W-1:0] b);
    return (b == '0) ? CNT_W'(1) : b;
  endfunction

endpackage

// File: rtl/ddram_rr_pick.sv
// Combinational round-robin picker: first pending slot after ptr, wrapping.
module ddram_rr_pick #(
  parameter int NCH = 4,
  parameter int IW  = 2
) (
  input  logic [NCH-1:0] pending,
  input  logic [IW-1:0]  ptr,
  output logic           valid,
  output logic [IW-1:0]  idx
);

  // Search ptr+1, ptr+2, ... ptr+NCH; ptr itself is looked at last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!valid && pending[(int'(ptr) + k) % NCH]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % NCH);
      end
    end
  end

endmodule

// File: rtl/ddram_rr_arbiter.sv
// Round-robin arbiter sharing one DDRAM master port among NCH clients.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no command outstanding; grant next pending slot
// WR     | write command on the bus, held until BUSY drops
// RDCMD  | read command on the bus, held until BUSY drops
// RDDATA | read accepted; forward beats to the granted channel
// DRAIN  | read interrupted by rst; swallow remaining beats silently
module ddram_rr_arbiter
  import ddram_arb_pkg::*;
#(
  parameter int            NCH       = 4,
  parameter logic [AW-1:0] ADDR_BASE = 29'h0C000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 DDRAM_BUSY,
  output logic [CNT_W-1:0]     DDRAM_BURSTCNT,
  output logic [AW-1:0]        DDRAM_ADDR,
  input  logic [DW-1:0]        DDRAM_DOUT,
  input  logic                 DDRAM_DOUT_READY,
  output logic                 DDRAM_RD,
  output logic [DW-1:0]        DDRAM_DIN,
  output logic [BE_W-1:0]      DDRAM_BE,
  output logic                 DDRAM_WE,
  input  logic [NCH*AW-1:0]    ch_addr,
  input  logic [NCH*CNT_W-1:0] ch_burst,
  input  logic [NCH-1:0]       ch_rd,
  input  logic [NCH-1:0]       ch_we,
  input  logic [NCH*DW-1:0]    ch_din,
  input  logic [NCH*BE_W-1:0]  ch_be,
  output logic [NCH-1:0]       ch_busy,
  output logic [DW-1:0]        ch_dout,
  output logic [NCH-1:0]       ch_dout_ready
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  arb_state_t       state, nstate;
  slot_t            slot [NCH];
  slot_t            pick_slot;
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   busy_q;
  logic [IW-1:0]    ptr, gnt, pick_idx, done_idx;
  logic             pick_valid;
  logic [CNT_W-1:0] beat_cnt;
  logic             done_q;
  logic             grant_en, cmd_acc, beat, last_beat, done_set;

  ddram_rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .pending (pend),
    .ptr     (ptr),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  assign pick_slot = slot[pick_idx];
  assign ch_busy   = busy_q;
  assign ch_dout   = DDRAM_DOUT;

  // State register.
  always_ff @(posedge clk) begin
    state <= nstate;
  end

  // Next state; rst keeps an accepted read alive in DRAIN so its beats are absorbed.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:   if (pick_valid) nstate = pick_slot.is_wr ? WR : RDCMD;
      WR:     if (!DDRAM_BUSY) nstate = IDLE;
      RDCMD:  if (!DDRAM_BUSY) nstate = RDDATA;
      RDDATA: if (last_beat) nstate = IDLE;
      DRAIN:  if (last_beat) nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (rst) begin
      if (state == RDDATA || state == DRAIN) nstate = last_beat ? IDLE : DRAIN;
      else if (state == RDCMD && !DDRAM_BUSY) nstate = DRAIN;
      else nstate = IDLE;
    end
  end

  // Decoded strobes and the combinational beat forward to the granted client.
  always_comb begin
    grant_en  = (state == IDLE) && pick_valid;
    cmd_acc   = (state == WR || state == RDCMD) && !DDRAM_BUSY;
    beat      = (state == RDDATA || state == DRAIN) && DDRAM_DOUT_READY;
    last_beat = beat && (beat_cnt == CNT_W'(1));
    done_set  = ((state == WR) && !DDRAM_BUSY) || ((state == RDDATA) && last_beat);
    ch_dout_ready = '0;
    if (state == RDDATA && DDRAM_DOUT_READY && !rst) ch_dout_ready[gnt] = 1'b1;
  end

  // Beat down-counter; deliberately not reset so an interrupted burst can drain.
  always_ff @(posedge clk) begin
    if (state == RDCMD && !DDRAM_BUSY) beat_cnt <= DDRAM_BURSTCNT;
    else if (beat)                     beat_cnt <= beat_cnt - CNT_W'(1);
  end

  // Request slots, busy flags, rotation pointer and the registered command.
  always_ff @(posedge clk) begin
    if (rst) begin
      DDRAM_WE <= 1'b0;
      DDRAM_RD <= 1'b0;
      busy_q   <= '0;
      pend     <= '0;
      ptr      <= IW'(NCH - 1);
      done_q   <= 1'b0;
    end else begin
      // ch_busy drops one cycle after the command completes.
      done_q <= done_set;
      if (done_set) done_idx <= gnt;
      if (done_q) busy_q[done_idx] <= 1'b0;

      for (int i = 0; i < NCH; i++) begin
        if (!busy_q[i] && (ch_we[i] || ch_rd[i])) begin
          slot[i].addr  <= ch_addr[i*AW +: AW];
          slot[i].burst <= ch_burst[i*CNT_W +: CNT_W];
          slot[i].din   <= ch_din[i*DW +: DW];
          slot[i].be    <= ch_be[i*BE_W +: BE_W];
          slot[i].is_wr <= ch_we[i];
          pend[i]       <= 1'b1;
          busy_q[i]     <= 1'b1;
        end
      end

      if (grant_en) begin
        ptr            <= pick_idx;
        gnt            <= pick_idx;
        pend[pick_idx] <= 1'b0;
        DDRAM_ADDR     <= pick_slot.addr + ADDR_BASE;
        DDRAM_DIN      <= pick_slot.din;
        DDRAM_BE       <= pick_slot.be;
        DDRAM_BURSTCNT <= pick_slot.is_wr ? CNT_W'(1) : norm_burst(pick_slot.burst);
        DDRAM_WE       <= pick_slot.is_wr;
        DDRAM_RD       <= !pick_slot.is_wr;
      end

      if (cmd_acc) begin
        DDRAM_WE <= 1'b0;
        DDRAM_RD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddram_rr_arbiter.sv
// Directed bench for ddram_rr_arbiter with NCH=4.
module tb_ddram_rr_arbiter;
  localparam int NCH = 4;
  localparam logic [28:0] BASE = 29'h0C000000;

  logic              clk = 1'b0;
  logic              rst;
  logic              DDRAM_BUSY;
  logic [7:0]        DDRAM_BURSTCNT;
  logic [28:0]       DDRAM_ADDR;
  logic [63:0]       DDRAM_DOUT;
  logic              DDRAM_DOUT_READY;
  logic              DDRAM_RD;
  logic [63:0]       DDRAM_DIN;
  logic [7:0]        DDRAM_BE;
  logic              DDRAM_WE;
  logic [NCH*29-1:0] ch_addr;
  logic [NCH*8-1:0]  ch_burst;
  logic [NCH-1:0]    ch_rd, ch_we;
  logic [NCH*64-1:0] ch_din;
  logic [NCH*8-1:0]  ch_be;
  logic [NCH-1:0]    ch_busy;
  logic [63:0]       ch_dout;
  logic [NCH-1:0]    ch_dout_ready;

  int n_chk = 0;
  int n_fail = 0;
  int wr_acc = 0;
  int rd_acc = 0;
  int rdy_cnt [NCH];

  ddram_rr_arbiter #(.NCH(NCH), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE),
    .ch_addr(ch_addr), .ch_burst(ch_burst), .ch_rd(ch_rd), .ch_we(ch_we), .ch_din(ch_din),
    .ch_be(ch_be), .ch_busy(ch_busy), .ch_dout(ch_dout), .ch_dout_ready(ch_dout_ready)
  );

  always #5 clk = ~clk;

  // Count accepted commands and forwarded beats per channel.
  initial for (int i = 0; i < NCH; i++) rdy_cnt[i] = 0;
  always @(negedge clk) begin
    if (DDRAM_WE && !DDRAM_BUSY) wr_acc++;
    if (DDRAM_RD && !DDRAM_BUSY) rd_acc++;
    for (int i = 0; i < NCH; i++) if (ch_dout_ready[i]) rdy_cnt[i]++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic rd, input logic we, input logic [28:0] a,
                         input logic [7:0] bl, input logic [63:0] d, input logic [7:0] be);
    ch_rd[i] = rd;
    ch_we[i] = we;
    ch_addr[i*29 +: 29] = a;
    ch_burst[i*8 +: 8] = bl;
    ch_din[i*64 +: 64] = d;
    ch_be[i*8 +: 8] = be;
  endtask

  task automatic clear_strobes();
    ch_rd = '0;
    ch_we = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    look();
    while (ch_busy != '0 && n < 60) begin
      look();
      n++;
    end
    check_val("idle_timeout", 64'(n < 60), 64'd1);
    step();
  endtask

  // Wait for a read command, accept it, then return `beats` data beats.
  task automatic serve_read(input int beats, output logic [28:0] a, output logic [7:0] bc);
    int n = 0;
    look();
    while (!DDRAM_RD && n < 40) begin
      look();
      n++;
    end
    check_val("rd_timeout", 64'(n < 40), 64'd1);
    a = DDRAM_ADDR;
    bc = DDRAM_BURSTCNT;
    for (int b = 0; b < beats; b++) begin
      step();
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT = 64'hBEEF_0000 + 64'(b);
    end
    step();
    DDRAM_DOUT_READY = 1'b0;
  endtask

  initial begin
    logic [28:0] a;
    logic [7:0]  bc;
    int          snap_w, snap_r, snap_q;
    int          n;

    rst = 1'b1;
    DDRAM_BUSY = 1'b0;
    DDRAM_DOUT = '0;
    DDRAM_DOUT_READY = 1'b0;
    ch_addr = '0; ch_burst = '0; ch_din = '0; ch_be = '0;
    clear_strobes();
    repeat (3) step();
    rst = 1'b0;
    look();
    check_val("rst_we", 64'(DDRAM_WE), 64'd0);
    check_val("rst_rd", 64'(DDRAM_RD), 64'd0);
    check_val("rst_busy", 64'(ch_busy), 64'd0);
    check_val("rst_rdy", 64'(ch_dout_ready), 64'd0);

    // Minimum-latency write on channel 2.
    step();
    set_req(2, 1'b0, 1'b1, 29'h100, 8'd0, 64'hA5A5_A5A5_A5A5_A5A5, 8'h0F);
    step(); clear_strobes();
    look();
    check_val("wr_busy_t1", 64'(ch_busy), 64'h4);
    check_val("wr_we_t1", 64'(DDRAM_WE), 64'd0);
    step(); look();
    check_val("wr_we_t2", 64'(DDRAM_WE), 64'd1);
    check_val("wr_addr", 64'(DDRAM_ADDR), 64'h0C000100);
    check_val("wr_be", 64'(DDRAM_BE), 64'h0F);
    check_val("wr_bc", 64'(DDRAM_BURSTCNT), 64'd1);
    check_val("wr_din", DDRAM_DIN, 64'hA5A5_A5A5_A5A5_A5A5);
    step(); look();
    check_val("wr_we_t3", 64'(DDRAM_WE), 64'd0);
    check_val("wr_busy_t3", 64'(ch_busy[2]), 64'd1);
    step(); look();
    check_val("wr_busy_t4", 64'(ch_busy[2]), 64'd0);

    // 4-beat read on channel 1.
    step();
    snap_q = rdy_cnt[1];
    set_req(1, 1'b1, 1'b0, 29'h40, 8'd4, 64'd0, 8'd0);
    step(); clear_strobes();
    step(); look();
    check_val("rd_rd_t2", 64'(DDRAM_RD), 64'd1);
    check_val("rd_bc", 64'(DDRAM_BURSTCNT), 64'd4);
    check_val("rd_addr", 64'(DDRAM_ADDR), 64'h0C000040);
    step();
    DDRAM_DOUT_READY = 1'b1;
    DDRAM_DOUT = 64'hD000;
    for (int b = 0; b < 4; b++) begin
      look();
      if (b == 0) check_val("rd_rd_t3", 64'(DDRAM_RD), 64'd0);
      check_val("rd_beat_rdy", 64'(ch_dout_ready), 64'h2);
      check_val("rd_beat_dout", ch_dout, 64'hD000 + 64'(b));
      step();
      DDRAM_DOUT_READY = (b < 3);
      DDRAM_DOUT = 64'hD000 + 64'(b + 1);
    end
    look();
    check_val("rd_busy_after1", 64'(ch_busy[1]), 64'd1);
    check_val("rd_nordy_after", 64'(ch_dout_ready), 64'd0);
    step(); look();
    check_val("rd_busy_after2", 64'(ch_busy[1]), 64'd0);
    check_val("rd_pulses", 64'(rdy_cnt[1] - snap_q), 64'd4);

    // Fresh reset so ptr=3, then all four channels strobe together, twice.
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NCH; i++)
        set_req(i, 1'b1, 1'b0, 29'h200 + 29'(i * 16), 8'd1, 64'd0, 8'd0);
      step(); clear_strobes();
      for (int i = 0; i < NCH; i++) begin
        serve_read(1, a, bc);
        check_val($sformatf("rr_order_r%0d_%0d", r, i), 64'(a), 64'(BASE + 29'h200 + 29'(i * 16)));
      end
      wait_idle();
    end

    // Write held off by BUSY for five cycles.
    snap_w = wr_acc;
    DDRAM_BUSY = 1'b1;
    set_req(3, 1'b0, 1'b1, 29'h333, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hF0);
    step(); clear_strobes();
    step();
    for (int k = 0; k < 5; k++) begin
      look();
      check_val("hold_we", 64'(DDRAM_WE), 64'd1);
      check_val("hold_addr", 64'(DDRAM_ADDR), 64'h0C000333);
      check_val("hold_din", DDRAM_DIN, 64'h0123_4567_89AB_CDEF);
      step();
    end
    DDRAM_BUSY = 1'b0;
    wait_idle();
    repeat (3) step();
    check_val("hold_one_write", 64'(wr_acc - snap_w), 64'd1);

    // Simultaneous read and write strobe on one channel: only the write goes out.
    snap_w = wr_acc;
    snap_r = rd_acc;
    set_req(0, 1'b1, 1'b1, 29'h50, 8'd3, 64'h77, 8'hFF);
    step(); clear_strobes();
    wait_idle();
    repeat (4) step();
    check_val("rdwe_writes", 64'(wr_acc - snap_w), 64'd1);
    check_val("rdwe_reads", 64'(rd_acc - snap_r), 64'd0);

    // Burst length 0 issues a single beat.
    snap_q = rdy_cnt[3];
    set_req(3, 1'b1, 1'b0, 29'h60, 8'd0, 64'd0, 8'd0);
    step(); clear_strobes();
    serve_read(1, a, bc);
    check_val("b0_bc", 64'(bc), 64'd1);
    check_val("b0_addr", 64'(a), 64'(BASE + 29'h60));
    wait_idle();
    check_val("b0_pulses", 64'(rdy_cnt[3] - snap_q), 64'd1);

    // rst after beat 2 of an 8-beat read; a write strobed during the drain waits.
    snap_q = rdy_cnt[2];
    set_req(2, 1'b1, 1'b0, 29'h700, 8'd8, 64'd0, 8'd0);
    step(); clear_strobes();
    serve_read(2, a, bc);
    check_val("drn_bc", 64'(bc), 64'd8);
    rst = 1'b1;
    look();
    check_val("drn_rst_rdy", 64'(ch_dout_ready), 64'd0);
    step();
    rst = 1'b0;
    set_req(1, 1'b0, 1'b1, 29'h111, 8'd0, 64'h5A5A, 8'hFF);
    DDRAM_DOUT_READY = 1'b1;
    for (int b = 0; b < 6; b++) begin
      look();
      if (b == 0) check_val("drn_busy_clr", 64'(ch_busy), 64'd0);
      check_val("drn_rdy", 64'(ch_dout_ready), 64'd0);
      check_val("drn_we", 64'(DDRAM_WE), 64'd0);
      check_val("drn_rd", 64'(DDRAM_RD), 64'd0);
      step();
      if (b == 0) clear_strobes();
      DDRAM_DOUT_READY = (b < 5);
    end
    n = 0;
    look();
    while (!DDRAM_WE && n < 20) begin
      n++;
      look();
    end
    check_val("drn_we_delay", 64'(n), 64'd1);
    check_val("drn_we_addr", 64'(DDRAM_ADDR), 64'h0C000111);
    check_val("drn_we_din", DDRAM_DIN, 64'h5A5A);
    wait_idle();
    check_val("drn_pulses", 64'(rdy_cnt[2] - snap_q), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
